// File: rtl/pdm_decimator.sv
// PDM microphone front end: mic clock generation, input synchronizer and a
// 2nd-order CIC decimator producing saturated signed 8-bit PCM with a valid strobe.
module pdm_decimator #(
    parameter int CLK_DIV = 32,
    parameter int DECIM   = 64
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable_in,
    input  logic       pdm_in,
    output logic       mic_clk_out,
    output logic [7:0] sample_out,
    output logic       sample_valid_out
);
    localparam int L  = $clog2(DECIM);
    localparam int W  = 2 * L + 2;
    localparam int SH = 2 * L - 7;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0]       DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]       DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [L-1:0]        DEC_LAST = L'(DECIM - 1);
    localparam logic signed [W-1:0] SAT_MAX  = W'(127);
    localparam logic signed [W-1:0] SAT_MIN  = W'(-128);

    logic [DW-1:0]       div_cnt;
    logic [L-1:0]        dec_cnt;
    logic [1:0]          warm_cnt;
    logic                comb_pend;
    logic                sync_1;
    logic                sync_2;
    logic signed [W-1:0] i1;
    logic signed [W-1:0] i2;
    logic signed [W-1:0] d1;
    logic signed [W-1:0] d2;

    logic                bit_strobe;
    logic signed [W-1:0] x;
    logic signed [W-1:0] i1_next;
    logic signed [W-1:0] c1;
    logic signed [W-1:0] y;
    logic signed [W-1:0] y_sh;
    logic [7:0]          sat_val;

    assign bit_strobe = enable_in && (div_cnt == DIV_LAST);
    assign x          = sync_2 ? W'(1) : W'(-1);
    assign i1_next    = i1 + x;
    // Integrators wrap freely; the comb differences recover the true value.
    assign c1         = i2 - d1;
    assign y          = c1 - d2;
    assign y_sh       = y >>> SH;

    always_comb begin
        sat_val = y_sh[7:0];
        if (y_sh > SAT_MAX) begin
            sat_val = 8'h7f;
        end else if (y_sh < SAT_MIN) begin
            sat_val = 8'h80;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pdm_in;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt          <= '0;
            dec_cnt          <= '0;
            warm_cnt         <= '0;
            comb_pend        <= 1'b0;
            i1               <= '0;
            i2               <= '0;
            d1               <= '0;
            d2               <= '0;
            mic_clk_out      <= 1'b0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else if (!enable_in) begin
            div_cnt          <= '0;
            dec_cnt          <= '0;
            warm_cnt         <= '0;
            comb_pend        <= 1'b0;
            i1               <= '0;
            i2               <= '0;
            d1               <= '0;
            d2               <= '0;
            mic_clk_out      <= 1'b0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            comb_pend        <= 1'b0;
            div_cnt          <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            mic_clk_out      <= (div_cnt < DIV_HALF);
            if (bit_strobe) begin
                i1 <= i1_next;
                i2 <= i2 + i1_next;
                if (dec_cnt == DEC_LAST) begin
                    dec_cnt   <= '0;
                    comb_pend <= 1'b1;
                end else begin
                    dec_cnt <= dec_cnt + L'(1);
                end
            end
            // The first two comb results only prime d1/d2 and are never emitted.
            if (comb_pend) begin
                d1 <= i2;
                d2 <= c1;
                if (warm_cnt == 2'd2) begin
                    sample_out       <= sat_val;
                    sample_valid_out <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: small config (CLK_DIV=4, DECIM=16) for
// most scenarios plus a default-parameter instance for the full-rate run.
module tb_pdm_decimator;
    localparam int CD      = 4;
    localparam int DM      = 16;
    localparam int P       = CD * DM;
    localparam int FIRST   = 3 * P + 1;
    localparam int P_B     = 32 * 64;
    localparam int FIRST_B = 3 * P_B + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              pdm = 1'b0;
    logic              mic;
    logic signed [7:0] smp;
    logic              vld;

    logic              rst_n_b = 1'b0;
    logic              en_b = 1'b0;
    logic              pdm_b = 1'b1;
    logic              mic_b;
    logic signed [7:0] smp_b;
    logic              vld_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cyc = 0;
    int exp_q[$];

    logic pat_bits[4];
    int   pat_len = 1;
    int   pat_idx = 0;

    pdm_decimator #(.CLK_DIV(CD), .DECIM(DM)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .pdm_in(pdm),
        .mic_clk_out(mic), .sample_out(smp), .sample_valid_out(vld)
    );

    pdm_decimator dut_b (
        .clk_in(clk), .rst_n_in(rst_n_b), .enable_in(en_b), .pdm_in(pdm_b),
        .mic_clk_out(mic_b), .sample_out(smp_b), .sample_valid_out(vld_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Behaves like a microphone: new data bit shortly after each mic clock rise.
    always @(posedge mic) begin
        #1;
        pdm = pat_bits[pat_idx % pat_len];
        pat_idx = pat_idx + 1;
    end

    task automatic set_pattern(input logic b0, input logic b1, input logic b2,
                               input logic b3, input int len);
        pat_bits[0] = b0;
        pat_bits[1] = b1;
        pat_bits[2] = b2;
        pat_bits[3] = b3;
        pat_len = len;
        pat_idx = 0;
    endtask

    task automatic start_small();
        @(negedge clk);
        pat_idx = 0;
        en = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic stop_small();
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_strobe(input bit which, input int budget,
                               output bit got, output int val, output int at);
        got = 1'b0;
        val = 0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? vld_b : vld) === 1'b1) begin
                got = 1'b1;
                val = which ? int'(smp_b) : int'(smp);
                at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mic !== 1'b0) begin
            errors++;
            $display("FAIL reset_mic got %0b expected 0", mic);
        end
        checks++;
        if (smp !== 8'sd0) begin
            errors++;
            $display("FAIL reset_sample got %0d expected 0", smp);
        end
        checks++;
        if (vld !== 1'b0 || vld_b !== 1'b0 || mic_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b/%0b/%0b expected 0/0/0", vld, vld_b, mic_b);
        end
        en = 1'b0;
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_ones();
        bit got;
        int val, at, prev, req, exp_v;
        set_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1);
        for (int n = 0; n < 4; n++) exp_q.push_back(127);
        start_small();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (mic !== ((k >= 1) && (((k - 1) % 4) < 2))) begin
                errors++;
                $display("FAIL mic_clk cycle %0d got %0b expected %0b", k, mic,
                         (k >= 1) && (((k - 1) % 4) < 2));
            end
            @(negedge clk);
        end
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_strobe(1'b0, FIRST + 10, got, val, at);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL ones_timeout output %0d got none expected strobe", n);
                break;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (val !== exp_v) begin
                errors++;
                $display("FAIL ones_value output %0d got %0d expected %0d", n, val, exp_v);
            end
            req = (n == 0) ? FIRST : P;
            checks++;
            if (((n == 0) ? at - en_cyc : at - prev) !== req) begin
                errors++;
                $display("FAIL ones_timing output %0d got %0d expected %0d", n,
                         (n == 0) ? at - en_cyc : at - prev, req);
            end
            prev = at;
        end
        exp_q.delete();
        stop_small();
    endtask

    task automatic test_pattern(input logic b0, input logic b1, input logic b2,
                                input logic b3, input int len, input int expv);
        bit got;
        int val, at, exp_v;
        set_pattern(b0, b1, b2, b3, len);
        for (int n = 0; n < 3; n++) exp_q.push_back(expv);
        start_small();
        for (int n = 0; n < 3; n++) begin
            wait_strobe(1'b0, FIRST + 10, got, val, at);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL pattern_timeout expect %0d output %0d got none", expv, n);
                break;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (val !== exp_v) begin
                errors++;
                $display("FAIL pattern_value output %0d got %0d expected %0d", n, val, exp_v);
            end
        end
        exp_q.delete();
        stop_small();
    endtask

    task automatic test_defaults();
        bit got;
        int val, at, prev, req, exp_v;
        for (int n = 0; n < 10; n++) exp_q.push_back(127);
        @(negedge clk);
        en_b = 1'b1;
        en_cyc = cyc;
        prev = 0;
        for (int n = 0; n < 10; n++) begin
            wait_strobe(1'b1, FIRST_B + 10, got, val, at);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL defaults_timeout output %0d got none expected strobe", n);
                break;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (val !== exp_v) begin
                errors++;
                $display("FAIL defaults_value output %0d got %0d expected %0d", n, val, exp_v);
            end
            req = (n == 0) ? FIRST_B : P_B;
            checks++;
            if (((n == 0) ? at - en_cyc : at - prev) !== req) begin
                errors++;
                $display("FAIL defaults_timing output %0d got %0d expected %0d", n,
                         (n == 0) ? at - en_cyc : at - prev, req);
            end
            prev = at;
        end
        exp_q.delete();
        @(negedge clk);
        en_b = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit got;
        int val, at, bad, prev, exp_v;
        set_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1);
        start_small();
        repeat (100) @(negedge clk);
        en = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mic !== 1'b0 || vld !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL enable_low_idle got %0d active cycles expected 0", bad);
        end
        for (int n = 0; n < 2; n++) exp_q.push_back(127);
        pat_idx = 0;
        en = 1'b1;
        en_cyc = cyc;
        prev = 0;
        for (int n = 0; n < 2; n++) begin
            wait_strobe(1'b0, FIRST + 10, got, val, at);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL reenable_timeout output %0d got none expected strobe", n);
                break;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (val !== exp_v) begin
                errors++;
                $display("FAIL reenable_value output %0d got %0d expected %0d", n, val, exp_v);
            end
            checks++;
            if (((n == 0) ? at - en_cyc : at - prev) !== ((n == 0) ? FIRST : P)) begin
                errors++;
                $display("FAIL reenable_timing output %0d got %0d expected %0d", n,
                         (n == 0) ? at - en_cyc : at - prev, (n == 0) ? FIRST : P);
            end
            prev = at;
        end
        exp_q.delete();
        // Drop enable during the comb cycle of the next output; it must not appear.
        while (cyc < prev + P - 1) @(negedge clk);
        en = 1'b0;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (vld !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pending_suppress got %0d strobes expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        int val, at, prev, exp_v;
        set_pattern(1'b1, 1'b1, 1'b1, 1'b1, 1);
        start_small();
        wait_strobe(1'b0, FIRST + 10, got, val, at);
        checks++;
        if (!got || val !== 127) begin
            errors++;
            $display("FAIL prereset_sample got %0d (strobe %0b) expected 127", val, got);
        end
        for (int k = 0; k < 8 && mic !== 1'b1; k++) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mic !== 1'b0 || smp !== 8'sd0 || vld !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got mic %0b sample %0d valid %0b expected 0 0 0",
                     mic, smp, vld);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pat_idx = 0;
        en_cyc = cyc;
        for (int n = 0; n < 2; n++) exp_q.push_back(127);
        prev = 0;
        for (int n = 0; n < 2; n++) begin
            wait_strobe(1'b0, FIRST + 10, got, val, at);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL restart_timeout output %0d got none expected strobe", n);
                break;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (val !== exp_v) begin
                errors++;
                $display("FAIL restart_value output %0d got %0d expected %0d", n, val, exp_v);
            end
            checks++;
            if (((n == 0) ? at - en_cyc : at - prev) !== ((n == 0) ? FIRST : P)) begin
                errors++;
                $display("FAIL restart_timing output %0d got %0d expected %0d", n,
                         (n == 0) ? at - en_cyc : at - prev, (n == 0) ? FIRST : P);
            end
            prev = at;
        end
        exp_q.delete();
        stop_small();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_pattern(1'b0, 1'b0, 1'b0, 1'b0, 1, -128);
        test_pattern(1'b1, 1'b1, 1'b1, 1'b0, 4, 64);
        test_pattern(1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        test_defaults();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
